// File: rtl/div32x32_seq_pkg.sv
// div_pkg: shared state encoding and sizing constants for the sequential divider
package div_pkg;
   localparam int DIV_WIDTH = 32;
   localparam int DIV_CNT_W = $clog2(DIV_WIDTH);
   typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} div_state_t;
endpackage

// File: rtl/div32x32_seq_if.sv
// div32x32_seq_if: start/busy issue handshake and result bus of the divider
// master drives start/dividend/divisor; slave (the divider) drives busy/quotient/remainder/div_by_zero
interface div32x32_seq_if import div_pkg::*; #(parameter int WIDTH = DIV_WIDTH) ();
   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;
   modport master (output start, dividend, divisor, input busy, quotient, remainder, div_by_zero);
   modport slave (input start, dividend, divisor, output busy, quotient, remainder, div_by_zero);
endinterface

// File: rtl/div32x32_seq_step.sv
// div_step: one combinational restoring-division step
// acc_i/qsh_i: partial remainder and dividend/quotient shift reg; divisor_i: divisor
// acc_o/qsh_o: values after shifting in one dividend bit and trying the subtraction
module div_step #(parameter int WIDTH = 32) (
   input  logic [WIDTH-1:0] acc_i,
   input  logic [WIDTH-1:0] qsh_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH-1:0] acc_o,
   output logic [WIDTH-1:0] qsh_o
);
   logic [WIDTH:0] shifted;
   logic [WIDTH:0] trial;
   logic           ok;
   // acc < divisor always holds, so the shifted acc fits in WIDTH+1 bits
   assign shifted = {acc_i, qsh_i[WIDTH-1]};
   assign trial   = shifted - {1'b0, divisor_i};
   assign ok      = ~trial[WIDTH];
   assign acc_o   = ok ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
   assign qsh_o   = {qsh_i[WIDTH-2:0], ok};
endmodule

// File: rtl/div32x32_seq.sv
// div32x32_seq: sequential unsigned restoring divider, one quotient bit per cycle
// clk: rising-edge clock; reset: async active-high
// bus (slave): start/dividend/divisor in, busy/quotient/remainder/div_by_zero out
module div32x32_seq import div_pkg::*; #(parameter int WIDTH = DIV_WIDTH) (
   input logic                 clk,
   input logic                 reset,
   div32x32_seq_if.slave       bus
);
   localparam int CW = $clog2(WIDTH);
   div_state_t       state_q, state_d;
   logic [WIDTH-1:0] dividend_q, dividend_d, divisor_q, divisor_d;
   logic [WIDTH-1:0] acc_q, acc_d, qsh_q, qsh_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] resq_q, resq_d, resr_q, resr_d;
   logic             resdbz_q, resdbz_d;
   logic [WIDTH-1:0] quot_q, quot_d, rem_q, rem_d;
   logic             dbz_q, dbz_d;
   logic [WIDTH-1:0] step_acc, step_qsh;
   div_step #(.WIDTH(WIDTH)) u_step (
      .acc_i(acc_q), .qsh_i(qsh_q), .divisor_i(divisor_q), .acc_o(step_acc), .qsh_o(step_qsh)
   );
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         dividend_q <= '0;
         divisor_q  <= '0;
         acc_q      <= '0;
         qsh_q      <= '0;
         cnt_q      <= '0;
         resq_q     <= '0;
         resr_q     <= '0;
         resdbz_q   <= 1'b0;
         quot_q     <= '0;
         rem_q      <= '0;
         dbz_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         dividend_q <= dividend_d;
         divisor_q  <= divisor_d;
         acc_q      <= acc_d;
         qsh_q      <= qsh_d;
         cnt_q      <= cnt_d;
         resq_q     <= resq_d;
         resr_q     <= resr_d;
         resdbz_q   <= resdbz_d;
         quot_q     <= quot_d;
         rem_q      <= rem_d;
         dbz_q      <= dbz_d;
      end
   end
   always_comb begin
      state_d    = state_q;
      dividend_d = dividend_q;
      divisor_d  = divisor_q;
      acc_d      = acc_q;
      qsh_d      = qsh_q;
      cnt_d      = cnt_q;
      resq_d     = resq_q;
      resr_d     = resr_q;
      resdbz_d   = resdbz_q;
      quot_d     = quot_q;
      rem_d      = rem_q;
      dbz_d      = dbz_q;
      case (state_q)
         IDLE: if (bus.start) begin
            dividend_d = bus.dividend;
            divisor_d  = bus.divisor;
            state_d    = LOAD;
         end
         LOAD: if (divisor_q == '0) begin
            resq_d   = '1;
            resr_d   = dividend_q;
            resdbz_d = 1'b1;
            state_d  = DONE;
         end else if (dividend_q < divisor_q) begin
            resq_d   = '0;
            resr_d   = dividend_q;
            resdbz_d = 1'b0;
            state_d  = DONE;
         end else begin
            acc_d   = '0;
            qsh_d   = dividend_q;
            cnt_d   = CW'(WIDTH - 1);
            state_d = ITER;
         end
         ITER: begin
            acc_d = step_acc;
            qsh_d = step_qsh;
            if (cnt_q == '0) begin
               resq_d   = step_qsh;
               resr_d   = step_acc;
               resdbz_d = 1'b0;
               state_d  = DONE;
            end else cnt_d = cnt_q - CW'(1);
         end
         DONE: begin
            quot_d  = resq_q;
            rem_d   = resr_q;
            dbz_d   = resdbz_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   assign bus.busy        = state_q != IDLE;
   assign bus.quotient    = quot_q;
   assign bus.remainder   = rem_q;
   assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_div32x32_seq.sv
// tb_div32x32_seq: scoreboard bench for the sequential divider
module tb_div32x32_seq;
   typedef struct {
      logic [31:0] a, b, q, r;
      logic        dbz;
      int          lat;
   } exp_t;
   logic clk = 1'b0;
   logic reset = 1'b1;
   exp_t sb[$];
   int pass = 0, total = 0;
   logic [31:0] last_q, last_r;
   div32x32_seq_if #(.WIDTH(32)) bus ();
   div32x32_seq #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end
   task automatic issue(input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      e.a = a;
      e.b = b;
      e.dbz = (b == 0);
      e.q = (b == 0) ? 32'hFFFF_FFFF : a / b;
      e.r = (b == 0) ? a : a % b;
      e.lat = (b == 0 || a < b) ? 2 : 34;
      sb.push_back(e);
      bus.start = 1'b1;
      bus.dividend = a;
      bus.divisor = b;
      @(negedge clk);
      bus.start = 1'b0;
      bus.dividend = $urandom;
      bus.divisor = $urandom;
   endtask
   task automatic wait_idle(input int pre, output int lat);
      lat = pre;
      while (bus.busy && lat < 200) begin
         lat++;
         @(negedge clk);
      end
   endtask
   task automatic test_reset;
      bus.start = 1'b0;
      bus.dividend = '0;
      bus.divisor = '0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      total += 2;
      if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else pass++;
      if ({bus.quotient, bus.remainder, bus.div_by_zero} !== 65'd0)
         $display("FAIL reset_outputs got q=%h r=%h dbz=%b want 0", bus.quotient, bus.remainder, bus.div_by_zero);
      else pass++;
      reset = 1'b0;
      @(negedge clk);
   endtask
   task automatic test_normal;
      logic [31:0] va[4] = '{32'd100, 32'd9, $urandom, $urandom | 32'h8000_0000};
      logic [31:0] vb[4] = '{32'd7, 32'd3, $urandom_range(1, 1000), $urandom_range(1, 65535)};
      for (int i = 0; i < 4; i++) begin
         exp_t e;
         int lat;
         issue(va[i], vb[i]);
         wait_idle(0, lat);
         e = sb.pop_front();
         total += 5;
         if (lat !== e.lat) $display("FAIL normal_lat %h/%h got %0d want %0d", e.a, e.b, lat, e.lat); else pass++;
         if (bus.quotient !== e.q) $display("FAIL normal_q %h/%h got %h want %h", e.a, e.b, bus.quotient, e.q); else pass++;
         if (bus.remainder !== e.r) $display("FAIL normal_r %h/%h got %h want %h", e.a, e.b, bus.remainder, e.r); else pass++;
         if (bus.div_by_zero !== 1'b0) $display("FAIL normal_dbz got %b want 0", bus.div_by_zero); else pass++;
         if (64'(bus.quotient) * 64'(e.b) + 64'(bus.remainder) !== 64'(e.a) || bus.remainder >= e.b)
            $display("FAIL normal_invariant %h/%h got q=%h r=%h", e.a, e.b, bus.quotient, bus.remainder);
         else pass++;
         last_q = e.q;
         last_r = e.r;
      end
   endtask
   task automatic test_early_exit;
      logic [31:0] va[3] = '{32'd5, 32'd0, 32'd65535};
      logic [31:0] vb[3] = '{32'd9, 32'd5, 32'd65536};
      for (int i = 0; i < 3; i++) begin
         exp_t e;
         int lat;
         issue(va[i], vb[i]);
         wait_idle(0, lat);
         e = sb.pop_front();
         total += 4;
         if (lat !== e.lat) $display("FAIL early_lat %h/%h got %0d want %0d", e.a, e.b, lat, e.lat); else pass++;
         if (bus.quotient !== e.q) $display("FAIL early_q %h/%h got %h want %h", e.a, e.b, bus.quotient, e.q); else pass++;
         if (bus.remainder !== e.r) $display("FAIL early_r %h/%h got %h want %h", e.a, e.b, bus.remainder, e.r); else pass++;
         if (bus.div_by_zero !== 1'b0) $display("FAIL early_dbz got %b want 0", bus.div_by_zero); else pass++;
      end
   endtask
   task automatic test_div_by_zero;
      logic [31:0] va[2] = '{32'h1234, 32'd10};
      logic [31:0] vb[2] = '{32'd0, 32'd3};
      for (int i = 0; i < 2; i++) begin
         exp_t e;
         int lat;
         issue(va[i], vb[i]);
         wait_idle(0, lat);
         e = sb.pop_front();
         total += 4;
         if (lat !== e.lat) $display("FAIL dbz_lat %h/%h got %0d want %0d", e.a, e.b, lat, e.lat); else pass++;
         if (bus.quotient !== e.q) $display("FAIL dbz_q %h/%h got %h want %h", e.a, e.b, bus.quotient, e.q); else pass++;
         if (bus.remainder !== e.r) $display("FAIL dbz_r %h/%h got %h want %h", e.a, e.b, bus.remainder, e.r); else pass++;
         if (bus.div_by_zero !== e.dbz) $display("FAIL dbz_flag %h/%h got %b want %b", e.a, e.b, bus.div_by_zero, e.dbz); else pass++;
      end
   endtask
   // each issue starts in the very first idle cycle after the previous result
   task automatic test_back_to_back;
      logic [31:0] va[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'd77, 32'h0000_0000};
      logic [31:0] vb[5] = '{32'd1, 32'hFFFF_FFFF, 32'h10, 32'd77, 32'd0};
      for (int i = 0; i < 5; i++) begin
         exp_t e;
         int lat;
         issue(va[i], vb[i]);
         wait_idle(0, lat);
         e = sb.pop_front();
         total += 4;
         if (lat !== e.lat) $display("FAIL b2b_lat %h/%h got %0d want %0d", e.a, e.b, lat, e.lat); else pass++;
         if (bus.quotient !== e.q) $display("FAIL b2b_q %h/%h got %h want %h", e.a, e.b, bus.quotient, e.q); else pass++;
         if (bus.remainder !== e.r) $display("FAIL b2b_r %h/%h got %h want %h", e.a, e.b, bus.remainder, e.r); else pass++;
         if (bus.div_by_zero !== e.dbz) $display("FAIL b2b_dbz %h/%h got %b want %b", e.a, e.b, bus.div_by_zero, e.dbz); else pass++;
         last_q = e.q;
         last_r = e.r;
      end
      issue(32'h8000_0000, 32'h10);
      begin
         exp_t e;
         int lat;
         wait_idle(0, lat);
         e = sb.pop_front();
         total++;
         if (bus.quotient !== 32'h0800_0000) $display("FAIL b2b_pow2 got %h want 08000000", bus.quotient); else pass++;
         last_q = e.q;
         last_r = e.r;
      end
   endtask
   task automatic test_ignore_start;
      exp_t e;
      int lat = 0;
      issue(32'd100, 32'd7);
      repeat (9) begin
         if (bus.busy) lat++;
         @(negedge clk);
      end
      total += 3;
      if (bus.busy !== 1'b1) $display("FAIL ignore_busy got %b want 1", bus.busy); else pass++;
      if (bus.quotient !== last_q) $display("FAIL ignore_hold_q got %h want %h", bus.quotient, last_q); else pass++;
      if (bus.remainder !== last_r) $display("FAIL ignore_hold_r got %h want %h", bus.remainder, last_r); else pass++;
      bus.start = 1'b1;
      bus.dividend = 32'd9;
      bus.divisor = 32'd3;
      if (bus.busy) lat++;
      @(negedge clk);
      bus.start = 1'b0;
      bus.dividend = 32'hDEAD_BEEF;
      bus.divisor = 32'h1;
      wait_idle(lat, lat);
      e = sb.pop_front();
      total += 3;
      if (lat !== 34) $display("FAIL ignore_lat got %0d want 34", lat); else pass++;
      if (bus.quotient !== e.q) $display("FAIL ignore_q got %h want %h", bus.quotient, e.q); else pass++;
      if (bus.remainder !== e.r) $display("FAIL ignore_r got %h want %h", bus.remainder, e.r); else pass++;
      repeat (3) @(negedge clk);
      total++;
      if (bus.busy !== 1'b0) $display("FAIL ignore_no_queue busy got %b want 0", bus.busy); else pass++;
   endtask
   task automatic test_reset_midop;
      exp_t e;
      int lat;
      issue(32'd100, 32'd7);
      repeat (14) @(negedge clk);
      #1 reset = 1'b1;
      #1;
      total += 2;
      if (bus.busy !== 1'b0) $display("FAIL midreset_busy got %b want 0", bus.busy); else pass++;
      if ({bus.quotient, bus.remainder, bus.div_by_zero} !== 65'd0)
         $display("FAIL midreset_outputs got q=%h r=%h dbz=%b want 0", bus.quotient, bus.remainder, bus.div_by_zero);
      else pass++;
      sb.delete();
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      total++;
      if (bus.busy !== 1'b0) $display("FAIL midreset_idle got %b want 0", bus.busy); else pass++;
      issue(32'd9, 32'd3);
      wait_idle(0, lat);
      e = sb.pop_front();
      total += 3;
      if (lat !== e.lat) $display("FAIL midreset_lat got %0d want %0d", lat, e.lat); else pass++;
      if (bus.quotient !== e.q) $display("FAIL midreset_q got %h want %h", bus.quotient, e.q); else pass++;
      if (bus.remainder !== e.r) $display("FAIL midreset_r got %h want %h", bus.remainder, e.r); else pass++;
   endtask
   initial begin
      test_reset();
      test_normal();
      test_early_exit();
      test_div_by_zero();
      test_back_to_back();
      test_ignore_start();
      test_reset_midop();
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end
endmodule
